microcode_loader: RTL and testbench



---
 rtl/microcode_loader_pkg.sv | 24 ++
 rtl/microcode_loader_if.sv | 23 ++
 rtl/microcode_loader.sv | 107 ++++++++++
 tb/tb_microcode_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/microcode_loader_pkg.sv
// rtl/microcode_loader_pkg.sv - shared constants and state encoding for the microcode loader
package microcode_loader_pkg;

    localparam int LOADER_MAX_LEN = 4096;
    localparam int CSUM_W         = 8;

    typedef logic [3:0] state_t;

    localparam state_t ST_HDR_LO    = 4'd0;
    localparam state_t ST_HDR_HI    = 4'd1;
    localparam state_t ST_WAIT_BYTE = 4'd2;
    localparam state_t ST_SETUP     = 4'd3;
    localparam state_t ST_STROBE    = 4'd4;
    localparam state_t ST_HOLD      = 4'd5;
    localparam state_t ST_CSUM      = 4'd6;
    localparam state_t ST_DONE      = 4'd7;
    localparam state_t ST_FAIL      = 4'd8;

    function automatic logic accepts_byte(input state_t st);
        return (st == ST_HDR_LO) || (st == ST_HDR_HI) ||
               (st == ST_WAIT_BYTE) || (st == ST_CSUM);
    endfunction

endpackage

// File: rtl/microcode_loader_if.sv
// rtl/microcode_loader_if.sv - image byte stream plus LUT bootstrap port of the loader
interface microcode_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        IN_DATA;
    logic              IN_VALID;
    logic              IN_READY;
    logic [ADDR_W-1:0] BOOTSTRAP_ADDR;
    logic [7:0]        BOOTSTRAP_DATA;
    logic              BOOTSTRAP_N_WE;
    logic              N_BOOTED;
    logic              ERROR;

    modport slave (
        input  IN_DATA, IN_VALID,
        output IN_READY, BOOTSTRAP_ADDR, BOOTSTRAP_DATA, BOOTSTRAP_N_WE, N_BOOTED, ERROR
    );

    modport master (
        output IN_DATA, IN_VALID,
        input  IN_READY, BOOTSTRAP_ADDR, BOOTSTRAP_DATA, BOOTSTRAP_N_WE, N_BOOTED, ERROR
    );
endinterface

// File: rtl/microcode_loader.sv
// rtl/microcode_loader.sv - framed byte-stream writer filling the microcode LUT at power-up
module microcode_loader
    import microcode_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = LOADER_MAX_LEN
) (
    input  logic              CLK,
    input  logic              N_RST,
    microcode_loader_if.slave bus
);
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [CSUM_W-1:0]   sum_q, sum_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                n_we_q, n_booted_q, error_q, in_ready_q;

    logic                xfer;
    logic [15:0]         hdr_len;
    logic                last_byte;

    assign xfer      = bus.IN_VALID & in_ready_q;
    assign hdr_len   = {bus.IN_DATA, len_q[7:0]};
    assign last_byte = (cnt_q + 16'd1) == len_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_HDR_LO: if (xfer) begin
                len_d[7:0] = bus.IN_DATA;
                state_d    = ST_HDR_HI;
            end
            ST_HDR_HI: if (xfer) begin
                len_d[15:8] = bus.IN_DATA;
                if ({1'b0, hdr_len} > DEPTH_L) state_d = ST_FAIL;
                else if (hdr_len == 16'd0)     state_d = ST_CSUM;
                else                           state_d = ST_WAIT_BYTE;
            end
            ST_WAIT_BYTE: if (xfer) begin
                data_d  = bus.IN_DATA;
                sum_d   = sum_q + bus.IN_DATA;
                state_d = ST_SETUP;
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_HOLD;
            // Address only advances when another byte follows, so a full-depth image never wraps.
            ST_HOLD: begin
                cnt_d = cnt_q + 16'd1;
                if (last_byte) begin
                    state_d = ST_CSUM;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_WAIT_BYTE;
                end
            end
            ST_CSUM: if (xfer) begin
                state_d = (bus.IN_DATA == sum_q) ? ST_DONE : ST_FAIL;
            end
            ST_DONE:  state_d = ST_DONE;
            ST_FAIL:  state_d = ST_FAIL;
            default:  state_d = ST_FAIL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!N_RST) begin
            state_q    <= ST_HDR_LO;
            len_q      <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            n_we_q     <= 1'b1;
            n_booted_q <= 1'b1;
            error_q    <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            n_we_q     <= (state_d != ST_STROBE);
            n_booted_q <= (state_d != ST_DONE);
            error_q    <= (state_d == ST_FAIL);
            in_ready_q <= accepts_byte(state_d);
        end
    end

    assign bus.IN_READY       = in_ready_q;
    assign bus.BOOTSTRAP_ADDR = addr_q;
    assign bus.BOOTSTRAP_DATA = data_q;
    assign bus.BOOTSTRAP_N_WE = n_we_q;
    assign bus.N_BOOTED       = n_booted_q;
    assign bus.ERROR          = error_q;

endmodule

// File: tb/tb_microcode_loader.sv
// tb/tb_microcode_loader.sv - scoreboard bench for microcode_loader
module tb_microcode_loader;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    microcode_loader_if #(.ADDR_W(12)) bus ();

    microcode_loader #(.ADDR_W(12), .DEPTH(4096)) dut (
        .CLK   (clk),
        .N_RST (n_rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int strobe_cnt = 0;
    int base;
    logic [11:0] last_strobe_addr = '0;

    logic [11:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    logic [7:0]  payload[$];
    logic [11:0] cur_addr;
    logic [7:0]  cur_data;
    bit prev_low = 1'b0;
    bit hold_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the next queued write and last one cycle.
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_low     = 1'b0;
            hold_pending = 1'b0;
        end else if (bus.BOOTSTRAP_N_WE === 1'b0) begin
            if (prev_low) begin
                check("strobe_width_cycles", 2, 1);
            end else begin
                strobe_cnt++;
                last_strobe_addr = bus.BOOTSTRAP_ADDR;
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_strobe_addr", {20'd0, bus.BOOTSTRAP_ADDR}, 32'hFFFF_FFFF);
                end else begin
                    cur_addr = exp_addr_q.pop_front();
                    cur_data = exp_data_q.pop_front();
                    check("strobe_addr", {20'd0, bus.BOOTSTRAP_ADDR}, {20'd0, cur_addr});
                    check("strobe_data", {24'd0, bus.BOOTSTRAP_DATA}, {24'd0, cur_data});
                    hold_pending = 1'b1;
                end
            end
            prev_low = 1'b1;
        end else begin
            if (hold_pending) begin
                check("hold_addr", {20'd0, bus.BOOTSTRAP_ADDR}, {20'd0, cur_addr});
                check("hold_data", {24'd0, bus.BOOTSTRAP_DATA}, {24'd0, cur_data});
            end
            hold_pending = 1'b0;
            prev_low     = 1'b0;
        end
    end

    task automatic do_reset();
        n_rst = 1'b0;
        bus.IN_VALID = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_n_we",     bus.BOOTSTRAP_N_WE, 1);
        check("rst_n_booted", bus.N_BOOTED, 1);
        check("rst_error",    bus.ERROR, 0);
        check("rst_in_ready", bus.IN_READY, 0);
        check("rst_addr",     {20'd0, bus.BOOTSTRAP_ADDR}, 0);
        check("rst_data",     {24'd0, bus.BOOTSTRAP_DATA}, 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        if (gap > 0) begin
            bus.IN_VALID = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        bus.IN_DATA  = b;
        bus.IN_VALID = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.IN_READY && waited < 64);
        if (!bus.IN_READY) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: byte 0x%0h not accepted after %0d cycles", b, waited);
        end
        @(posedge clk);
        #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic send_payload(input bit rnd_gaps);
        int gap;
        for (int i = 0; i < payload.size(); i++) begin
            exp_addr_q.push_back(12'(i));
            exp_data_q.push_back(payload[i]);
            gap = 0;
            if (rnd_gaps && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 4);
            send_byte(payload[i], gap);
        end
    endtask

    task automatic check_end(input string tag, input int exp_strobes, input bit exp_booted);
        @(negedge clk);
        check({tag, "_n_booted"}, bus.N_BOOTED, exp_booted ? 0 : 1);
        check({tag, "_error"},    bus.ERROR, exp_booted ? 0 : 1);
        check({tag, "_in_ready"}, bus.IN_READY, 0);
        check({tag, "_strobes"},  strobe_cnt - base, exp_strobes);
        check({tag, "_pending"},  exp_addr_q.size(), 0);
    endtask

    initial begin
        int waited;
        n_rst = 1'b0;
        bus.IN_VALID = 1'b0;
        bus.IN_DATA  = 8'h00;
        @(posedge clk);
        #1;

        // Two-byte image, valid held high
        do_reset();
        base = strobe_cnt;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        payload = '{8'hAA, 8'h55};
        send_payload(1'b0);
        check("t1_n_booted_before_csum", bus.N_BOOTED, 1);
        send_byte(8'hFF, 0);
        check_end("t1", 2, 1'b1);

        // Bad checksum
        do_reset();
        base = strobe_cnt;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        payload = '{8'h10};
        send_payload(1'b0);
        send_byte(8'h11, 0);
        check_end("t2", 1, 1'b0);
        repeat (3) @(negedge clk);
        check("t2_in_ready_later", bus.IN_READY, 0);

        // Oversized length header
        do_reset();
        base = strobe_cnt;
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        check_end("t3", 0, 1'b0);

        // Empty image, good and bad checksum
        do_reset();
        base = strobe_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_end("t4a", 0, 1'b1);
        do_reset();
        base = strobe_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        check_end("t4b", 0, 1'b0);

        // Full-depth image with random valid gaps; checksum of 16 x (0..255) is 0x00
        do_reset();
        base = strobe_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h10, 1);
        payload.delete();
        for (int i = 0; i < 4096; i++) payload.push_back(8'(i));
        send_payload(1'b1);
        send_byte(8'h00, 2);
        check_end("t5", 4096, 1'b1);
        check("t5_last_strobe_addr", {20'd0, last_strobe_addr}, 32'hFFF);

        // Reset during the strobe of the third byte, then a fresh image
        do_reset();
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        payload = '{8'hA0, 8'hA1, 8'hA2};
        send_payload(1'b0);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.BOOTSTRAP_N_WE !== 1'b0 && waited < 16);
        check("t6_strobe3_seen", bus.BOOTSTRAP_N_WE, 0);
        check("t6_strobe3_addr", {20'd0, bus.BOOTSTRAP_ADDR}, 2);
        #1;
        do_reset();
        check("t6_pending_after_rst", exp_addr_q.size(), 0);
        base = strobe_cnt;
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        payload = '{8'h01, 8'h02, 8'h03};
        send_payload(1'b0);
        send_byte(8'h06, 0);
        check_end("t6", 3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
